// File: rtl/kbd_scan_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes and the Pause sequence into key events
// and queues them in a FWFT FIFO. Define KBD_REPEAT_FILTER_EN to drop typematic repeats.
module kbd_scan_ctrl #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       key_avail,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP} state_t;

    state_t        state_reg;
    logic [2:0]    skip_reg;
    logic [TW-1:0] to_cnt_reg;
    logic          push_pend_reg;
    logic [9:0]    push_data_reg;

    logic       is_err;
    logic       ev_valid;
    logic       ev_ext;
    logic       ev_brk;
    logic [7:0] ev_code;
    logic       ev_push;
    logic       timeout_hit;

    // Decode the byte arriving this cycle into a candidate event.
    always_comb begin
        is_err   = (rx_data == 8'h00) || (rx_data == 8'hFF);
        ev_valid = 1'b0;
        ev_ext   = 1'b0;
        ev_brk   = 1'b0;
        ev_code  = rx_data;
        if (rx_valid) begin
            case (state_reg)
                S_IDLE:   ev_valid = !is_err && rx_data != 8'hE0 && rx_data != 8'hF0 && rx_data != 8'hE1;
                S_EXT: begin
                    ev_valid = !is_err && rx_data != 8'hF0 && rx_data != 8'hE0;
                    ev_ext   = 1'b1;
                end
                S_BRK: begin
                    ev_valid = !is_err && rx_data != 8'hE0 && rx_data != 8'hF0;
                    ev_brk   = 1'b1;
                end
                S_EXTBRK: begin
                    ev_valid = !is_err;
                    ev_ext   = 1'b1;
                    ev_brk   = 1'b1;
                end
                S_SKIP: begin
                    ev_valid = (skip_reg == 3'd1);
                    ev_code  = 8'hE1;
                end
                default: ev_valid = 1'b0;
            endcase
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (state_reg != S_IDLE) && !rx_valid
                         && (to_cnt_reg == TW'(TIMEOUT - 1));

`ifdef KBD_REPEAT_FILTER_EN
    logic [8:0] last_make_reg;
    logic       last_valid_reg;
    logic       make_match;

    assign make_match = last_valid_reg && (last_make_reg == {ev_ext, ev_code});
    assign ev_push    = ev_valid && !(!ev_brk && make_match);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_make_reg  <= '0;
            last_valid_reg <= 1'b0;
        end else if (ev_valid) begin
            if (!ev_brk && !make_match) begin
                last_make_reg  <= {ev_ext, ev_code};
                last_valid_reg <= 1'b1;
            end else if (ev_brk && make_match) begin
                last_valid_reg <= 1'b0;
            end
        end
    end
`else
    assign ev_push = ev_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            skip_reg      <= '0;
            to_cnt_reg    <= '0;
            push_pend_reg <= 1'b0;
            push_data_reg <= '0;
        end else begin
            push_pend_reg <= ev_push;
            push_data_reg <= {ev_ext, ev_brk, ev_code};
            if (timeout_hit) begin
                state_reg  <= S_IDLE;
                to_cnt_reg <= '0;
            end else if (rx_valid) begin
                to_cnt_reg <= '0;
                case (state_reg)
                    S_IDLE: begin
                        if (rx_data == 8'hE0) begin
                            state_reg <= S_EXT;
                        end else if (rx_data == 8'hF0) begin
                            state_reg <= S_BRK;
                        end else if (rx_data == 8'hE1) begin
                            state_reg <= S_SKIP;
                            skip_reg  <= 3'd7;
                        end
                    end
                    S_EXT: begin
                        if (rx_data == 8'hF0)
                            state_reg <= S_EXTBRK;
                        else if (rx_data != 8'hE0)
                            state_reg <= S_IDLE;
                    end
                    S_BRK: begin
                        if (rx_data != 8'hE0 && rx_data != 8'hF0)
                            state_reg <= S_IDLE;
                    end
                    S_EXTBRK: state_reg <= S_IDLE;
                    S_SKIP: begin
                        skip_reg <= skip_reg - 3'd1;
                        if (skip_reg == 3'd1)
                            state_reg <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end else if (state_reg != S_IDLE && TIMEOUT != 0) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
        end
    end

    // FIFO: array storage, head entry held in a register so it survives going empty.
    logic [9:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [9:0]    head_reg;
    logic          overflow_reg;

    logic          do_pop;
    logic          do_wr;
    logic          is_full;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_next;

    assign is_full     = (count_reg == (AW + 1)'(DEPTH));
    assign do_pop      = rd_en && (count_reg != '0);
    assign do_wr       = push_pend_reg && (!is_full || do_pop);
    assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);
    assign count_next  = count_reg + (AW + 1)'(do_wr) - (AW + 1)'(do_pop);

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr_reg] <= push_data_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(do_wr);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // The new head is the entry being written only when it lands exactly at the new read slot.
            if (count_next != '0) begin
                if (do_wr && rd_ptr_next == wr_ptr_reg)
                    head_reg <= push_data_reg;
                else
                    head_reg <= mem[rd_ptr_next];
            end
            if (push_pend_reg && !do_wr)
                overflow_reg <= 1'b1;
            else if (clr_ovf)
                overflow_reg <= 1'b0;
        end
    end

    assign key_ext   = head_reg[9];
    assign key_brk   = head_reg[8];
    assign key_code  = head_reg[7:0];
    assign key_avail = (count_reg != '0);
    assign fifo_full = is_full;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl with hand-computed expected FIFO entries.
module tb_kbd_scan_ctrl;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_en;
    logic       clr_ovf;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_brk;
    logic       key_avail;
    logic       fifo_full;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    kbd_scan_ctrl #(.DEPTH(8), .AW(3), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .key_code(key_code), .key_ext(key_ext),
        .key_brk(key_brk), .key_avail(key_avail), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else begin
            n_pass++;
            $display("check %s: %0h", tag, obs);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pop();
        @(posedge clk); #1;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic expect_pop(input string tag, input logic [9:0] exp);
        check(tag, {22'd0, key_ext, key_brk, key_code}, {22'd0, exp});
        pop();
    endtask

    initial begin
        logic [9:0] exp_q[$];
        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {19'd0, key_avail, fifo_full, overflow, key_ext, key_brk, key_code}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_outputs", {19'd0, key_avail, fifo_full, overflow, key_ext, key_brk, key_code}, 32'd0);

        // Make then break, with key_avail latency
        send(8'h1C);
        check("avail_lat_1cyc", key_avail, 0);
        @(posedge clk); #1;
        check("avail_lat_2cyc", key_avail, 1);
        send(8'hF0); send(8'h1C); settle();
        expect_pop("make_1c", 10'h01C);
        expect_pop("break_1c", 10'h11C);
        check("empty_after_drain", key_avail, 0);
        check("head_holds_when_empty", {22'd0, key_ext, key_brk, key_code}, 32'h11C);

        // Extended make/break
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75); settle();
        expect_pop("ext_make_75", 10'h275);
        expect_pop("ext_break_75", 10'h375);

        // Pause sequence, then an ordinary key proves the decoder is back in IDLE
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h2A); settle();
        expect_pop("pause_entry", 10'h0E1);
        expect_pop("after_pause", 10'h02A);
        check("pause_single_entry", key_avail, 0);

        // Timeout abandons E0; error byte abandons E0; one cycle short keeps E0
        send(8'hE0);
        repeat (TO - 1) @(posedge clk);
        send(8'h1C); settle();
        expect_pop("timeout_drops_ext", 10'h01C);
        send(8'hE0); send(8'hFF); send(8'h1D); settle();
        expect_pop("err_drops_ext", 10'h01D);
        send(8'hE0);
        repeat (TO - 2) @(posedge clk);
        send(8'h75); settle();
        expect_pop("just_before_timeout", 10'h275);

        // Pop while empty is ignored
        pop();
        send(8'h33); settle();
        expect_pop("pop_empty_ignored", 10'h033);
        check("empty_again", key_avail, 0);

        // Overflow
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        settle();
        check("full_after_9", fifo_full, 1);
        check("ovf_after_9", overflow, 1);
        check("head_after_9", {22'd0, key_ext, key_brk, key_code}, 32'h010);
        @(posedge clk); #1; clr_ovf = 1'b1;
        @(posedge clk); #1; clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);
        check("still_full", fifo_full, 1);
        send(8'h20);
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        check("push_pop_full_no_ovf", overflow, 0);
        check("push_pop_full_count", fifo_full, 1);
        for (int i = 1; i < 8; i++) expect_pop($sformatf("drain_%0d", i), {2'b00, 8'h10 + 8'(i)});
        expect_pop("drain_last", 10'h020);
        check("drained", key_avail, 0);

        // Typematic repeats
        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C);
        send(8'h1C); settle();
`ifdef KBD_REPEAT_FILTER_EN
        exp_q = '{10'h01C, 10'h11C, 10'h01C};
`else
        exp_q = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
        foreach (exp_q[i]) begin
            check($sformatf("repeat_avail_%0d", i), key_avail, 1);
            expect_pop($sformatf("repeat_entry_%0d", i), exp_q[i]);
        end
        check("repeat_count_end", key_avail, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
- Sequences the raw PS/2 byte stream from the keyboard receiver into complete key events.
- Resolves the 0xE0 (extended) and 0xF0 (break) prefixes and swallows the 8-byte Pause sequence.
- Queues decoded events in a small first-word-fall-through FIFO that the processor drains with a read strobe.
- Sits between the PS/2 receiver and the picoVOS processor port decode.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- AW, 3, FIFO address width; log2(DEPTH).
- TIMEOUT, 100000, cycles allowed between prefix and next byte before the sequence is abandoned (2 ms at 50 MHz); 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  byte from the PS/2 receiver
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- rd_en  in  1  pop the head entry (ignored when empty)
- clr_ovf  in  1  clear the overflow flag
- key_code  out  8  head entry scan code
- key_ext  out  1  head entry is E0-extended
- key_brk  out  1  head entry is a release
- key_avail  out  1  FIFO not empty
- fifo_full  out  1  FIFO holds DEPTH entries
- overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset: FSM enters IDLE; ext/brk flags, skip counter, timeout counter and FIFO pointers clear to 0. All outputs are 0.
- Decoder FSM; each state transition is taken on a cycle with rx_valid=1:
  - IDLE:
    - 0xE0 -> EXT.
    - 0xF0 -> BRK, brk=1.
    - 0xE1 -> SKIP, skip count=7.
    - 0x00 or 0xFF (keyboard error) -> discarded, stay IDLE.
    - Any other byte -> push {0,0,byte}.
  - EXT:
    - 0xF0 -> EXTBRK.
    - 0xE0 -> stay in EXT.
    - 0x00 or 0xFF -> IDLE, no push.
    - Other -> push {1,0,byte}, go to IDLE.
  - BRK:
    - 0xE0 / 0xF0 -> stay in BRK.
    - 0x00 or 0xFF -> IDLE.
    - Other -> push {0,1,byte}, go to IDLE.
  - EXTBRK:
    - 0x00 or 0xFF -> IDLE.
    - Other -> push {1,1,byte}, go to IDLE.
  - SKIP:
    - Each byte decrements the skip count.
    - The byte that takes the count from 1 to 0 pushes {0,0,0xE1} and returns to IDLE.
- Timeout:
  - In EXT, BRK, EXTBRK or SKIP, the counter increments every cycle with rx_valid=0 and clears on rx_valid.
  - When the counter reaches TIMEOUT: go to IDLE, no push, counter clears.
  - The counter stays 0 in IDLE.
- Push timing: a push is written in the cycle after the rx_valid cycle. key_avail asserts 2 cycles after the final rx_valid.
- FIFO:
  - Entry format is {ext,brk,code}, 10 bits.
  - key_code/key_ext/key_brk always show the head entry; they hold their last value when empty.
  - rd_en with key_avail=1 advances the head on the next edge.
- Full:
  - A push while full is dropped and sets overflow on the same edge.
  - If rd_en and a push coincide while full, both take effect; nothing is dropped and overflow is not set.
- Empty: rd_en is ignored and the pointers do not move.
- A push and a pop in the same cycle leave the count unchanged.
- Pointers wrap modulo DEPTH; the count is AW+1 bits.
- clr_ovf clears overflow. If clr_ovf and a new drop coincide, overflow remains set.

Optional Feature:
- Macro: KBD_REPEAT_FILTER_EN.
- Defined:
  - A last_make register (9 bits {ext,code}, plus a valid bit) suppresses typematic repeats.
  - A make event whose {ext,code} equals last_make while valid is not pushed.
  - A make event that is pushed loads last_make and sets valid.
  - A break event whose {ext,code} matches last_make clears valid; it is always pushed.
  - Reset clears valid.
- Undefined: every make is pushed, including repeats. No last_make register is built.

Test Plan:
- rx bytes 0x1C, then 0xF0,0x1C -> two entries {0,0,0x1C}, {0,1,0x1C}. key_avail rises 2 cycles after the first strobe.
- rx 0xE0,0x75, then 0xE0,0xF0,0x75 -> entries {1,0,0x75}, {1,1,0x75}.
- rx E1 14 77 E1 F0 14 F0 77 -> exactly one entry, {0,0,0xE1}; the decoder returns to IDLE.
- rx 0xE0, then idle for TIMEOUT cycles, then 0x1C -> single entry {0,0,0x1C} (not extended). Same result with 0xFF in place of the idle gap.
- Push 9 makes with DEPTH=8 and no reads -> fifo_full=1, overflow=1, entry 9 lost. clr_ovf -> overflow=0. Pushing while full with rd_en=1 -> no overflow, count stays 8.
- With KBD_REPEAT_FILTER_EN: rx 0x1C x3, then F0 1C, then 0x1C -> entries make, break, make (3 total). Without the macro: 5 entries.
